// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, cell type and reader FSM states.
package board_pkg;

    localparam int ROWS   = 16;
    localparam int COLS   = 32;
    localparam int CELL_W = 6;
    localparam int ADR_W  = 9;

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_LATCH,
        ST_DONE
    } reader_state_e;

endpackage

// File: rtl/board_scan_counter.sv
// board_scan_counter: row/column position of the frame scan.
// clear has priority; next_row moves to column 0 of the following row;
// inc_col steps the column within the current row.
module board_scan_counter #(
    parameter int ROWS = board_pkg::ROWS,
    parameter int COLS = board_pkg::COLS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inc_col,
    input  logic                      next_row,
    input  logic                      clear,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [$clog2(COLS)-1:0]   col,
    output logic                      last_col,
    output logic                      last_row
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    // Position counters; the column only wraps through next_row.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (next_row) begin
            r_row <= r_row + 1'b1;
            r_col <= '0;
        end else if (inc_col) begin
            r_col <= r_col + 1'b1;
        end
    end

    assign row      = r_row;
    assign col      = r_col;
    assign last_col = (r_col == COL_W'(COLS - 1));
    assign last_row = (r_row == ROW_W'(ROWS - 1));

endmodule

// File: rtl/board_reader.sv
// board_reader: walks the 512-cell board memory row-major, presents each
// cell over a valid/ready handshake, pulses latch after every row and
// donesending at frame end.
// Optional build macro BOARD_READER_AUTOREPEAT_EN: frames restart
// automatically after DONE instead of returning to IDLE.
module board_reader
    import board_pkg::*;
#(
    parameter int ROWS   = board_pkg::ROWS,
    parameter int COLS   = board_pkg::COLS,
    parameter int CELL_W = board_pkg::CELL_W,
    parameter int ADR_W  = board_pkg::ADR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADR_W-1:0]        adr,
    input  logic [CELL_W-1:0]       rd,
    output logic [CELL_W-1:0]       pixel_data,
    output logic                    pixel_valid,
    input  logic                    pixel_ready,
    output logic [$clog2(ROWS)-1:0] row,
    output logic [$clog2(COLS)-1:0] col,
    output logic                    latch,
    output logic                    donesending,
    output logic                    busy
);

    reader_state_e           r_state;
    logic [CELL_W-1:0]       r_pixel_data;
    logic                    r_pixel_valid;
    logic                    r_latch;
    logic                    r_donesending;
    logic                    r_busy;

    logic [$clog2(ROWS)-1:0] w_row;
    logic [$clog2(COLS)-1:0] w_col;
    logic                    w_last_col;
    logic                    w_last_row;
    logic                    w_inc_col;
    logic                    w_next_row;
    logic                    w_clear;

    // Counter steering: each control is active for exactly one FSM transition.
    assign w_clear    = ((r_state == ST_IDLE) && start) || (r_state == ST_DONE);
    assign w_inc_col  = (r_state == ST_PRESENT) && pixel_ready && !w_last_col;
    assign w_next_row = (r_state == ST_LATCH) && !w_last_row;

    board_scan_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_scan_counter (
        .clk      (clk),
        .reset    (reset),
        .inc_col  (w_inc_col),
        .next_row (w_next_row),
        .clear    (w_clear),
        .row      (w_row),
        .col      (w_col),
        .last_col (w_last_col),
        .last_row (w_last_row)
    );

    // Frame FSM with registered handshake, pulse and busy outputs.
    // NOTE: every register here uses <= so all branches read the pre-edge
    // values of r_state and the counters; blocking = would let later
    // statements see half-updated state and break the cycle timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_latch       <= 1'b0;
            r_donesending <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_latch       <= 1'b0;
            r_donesending <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_pixel_data  <= rd;
                    r_pixel_valid <= 1'b1;
                    r_state       <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (pixel_ready) begin
                        r_pixel_valid <= 1'b0;
                        if (w_last_col) begin
                            r_state <= ST_LATCH;
                            r_latch <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_last_row) begin
                        r_state       <= ST_DONE;
                        r_donesending <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
`ifdef BOARD_READER_AUTOREPEAT_EN
                    r_state <= ST_FETCH;
`else
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign adr         = {w_row, w_col};
    assign row         = w_row;
    assign col         = w_col;
    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;
    assign latch       = r_latch;
    assign donesending = r_donesending;
    assign busy        = r_busy;

endmodule
